// File: rtl/ro_freq_meter.sv
// Multi-channel ring-oscillator enable and frequency meter: powers one oscillator at a time,
// lets it settle, then counts synchronized rising edges over a fixed window of clk cycles.
module ro_freq_meter #(
    parameter int NUM_CH        = 4,
    parameter int SEL_W         = 2,
    parameter int SETTLE_CYCLES = 8,
    parameter int GATE_CYCLES   = 1024,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [NUM_CH-1:0]   osc_in,
    input  logic [SEL_W-1:0]    ch_sel,
    input  logic                start,
    input  logic                cont,
    output logic [NUM_CH-1:0]   osc_en,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    result,
    output logic                ovf
);

    localparam int TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [SEL_W:0]   NUM_CH_V    = (SEL_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_GATE   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [TMR_W-1:0]  tmr_r;
    logic [SEL_W-1:0]  ch_r;
    logic [SEL_W-1:0]  ch_nxt_s;
    logic [NUM_CH-1:0] sync1_r;
    logic [NUM_CH-1:0] sync2_r;
    logic              prev_r;
    logic              sel_bit_s;
    logic              edge_s;
    logic              ch_ok_s;
    logic              start_ok_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              ovf_acc_r;
    logic              ovf_inc_s;
    logic [NUM_CH-1:0] osc_en_r;
    logic              busy_r;
    logic              done_r;
    logic [CNT_W-1:0]  result_r;
    logic              ovf_r;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [SEL_W-1:0] ch);
        logic [NUM_CH-1:0] oh;
        oh = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            oh[i] = (ch == SEL_W'(i));
        end
        return oh;
    endfunction

    // Selected synchronized oscillator bit, start qualification and edge detect.
    always_comb begin
        sel_bit_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_bit_s = sel_bit_s | (sync2_r[i] & (ch_r == SEL_W'(i)));
        end
        ch_ok_s    = ({1'b0, ch_sel} < NUM_CH_V);
        start_ok_s = start & ena & ch_ok_s;
        edge_s     = sel_bit_s & ~prev_r;
    end

    // Next-state logic; a low ena overrides everything and returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        if (!ena) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   state_nxt_s = start_ok_s ? ST_SETTLE : ST_IDLE;
                ST_SETTLE: state_nxt_s = (tmr_r == SETTLE_LAST) ? ST_GATE : ST_SETTLE;
                ST_GATE:   state_nxt_s = (tmr_r == GATE_LAST) ? ST_DONE : ST_GATE;
                ST_DONE:   state_nxt_s = cont ? ST_GATE : ST_IDLE;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end
        ch_nxt_s = ((state_r == ST_IDLE) && (state_nxt_s == ST_SETTLE)) ? ch_sel : ch_r;
    end

    // Saturating edge count; the sticky overflow bit sets when an edge arrives at all-ones.
    always_comb begin
        cnt_inc_s = cnt_r;
        ovf_inc_s = ovf_acc_r;
        if ((state_r == ST_GATE) && edge_s) begin
            if (cnt_r == CNT_MAX) begin
                ovf_inc_s = 1'b1;
            end else begin
                cnt_inc_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_inc_s = cnt_r;
        end
    end

    // Two-flop synchronizers plus the previous-value flop of the selected channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {NUM_CH{1'b0}};
            sync2_r <= {NUM_CH{1'b0}};
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= osc_in;
            sync2_r <= sync1_r;
            prev_r  <= sel_bit_s;
        end
    end

    // State, phase timer, latched channel and edge counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            tmr_r     <= {TMR_W{1'b0}};
            ch_r      <= {SEL_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            ovf_acc_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ch_r    <= ch_nxt_s;
            if ((state_nxt_s == state_r) && ((state_r == ST_SETTLE) || (state_r == ST_GATE))) begin
                tmr_r <= tmr_r + TMR_W'(1);
            end else begin
                tmr_r <= {TMR_W{1'b0}};
            end
            // Counter only runs in GATE; every other state leaves it cleared for the next window.
            if (state_r == ST_GATE) begin
                cnt_r     <= cnt_inc_s;
                ovf_acc_r <= ovf_inc_s;
            end else begin
                cnt_r     <= {CNT_W{1'b0}};
                ovf_acc_r <= 1'b0;
            end
        end
    end

    // Registered outputs, loaded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osc_en_r <= {NUM_CH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {CNT_W{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            busy_r   <= (state_nxt_s != ST_IDLE);
            osc_en_r <= (state_nxt_s != ST_IDLE) ? ch_onehot(ch_nxt_s) : {NUM_CH{1'b0}};
            done_r   <= (state_nxt_s == ST_DONE);
            if ((state_r == ST_GATE) && (state_nxt_s == ST_DONE)) begin
                result_r <= cnt_inc_s;
                ovf_r    <= ovf_inc_s;
            end else begin
                result_r <= result_r;
                ovf_r    <= ovf_r;
            end
        end
    end

    assign osc_en = osc_en_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign ovf    = ovf_r;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Self-checking bench for ro_freq_meter: per-cycle oscillator waveforms are recorded and the
// expected count is derived from the recorded pin history and the documented window timing.
module tb_ro_freq_meter;

    localparam int NCH  = 3;
    localparam int SW   = 2;
    localparam int S    = 8;
    localparam int G    = 1024;
    localparam int CW   = 8;
    localparam int MAXV = 255;
    localparam int HMAX = 32768;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena = 1'b0;
    logic [NCH-1:0] osc_in = '0;
    logic [SW-1:0]  ch_sel = '0;
    logic           start = 1'b0;
    logic           cont = 1'b0;
    logic [NCH-1:0] osc_en;
    logic           busy;
    logic           done;
    logic [CW-1:0]  result;
    logic           ovf;

    ro_freq_meter #(
        .NUM_CH(NCH), .SEL_W(SW), .SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .ch_sel(ch_sel),
        .start(start), .cont(cont), .osc_en(osc_en), .busy(busy), .done(done),
        .result(result), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int             n_checks = 0;
    int             n_errors = 0;
    int             cyc = 0;
    int             per [NCH];
    int             ph [NCH];
    logic [NCH-1:0] hist [HMAX];
    int             last_res = 0;
    int             last_ovf = 0;
    int             dbl_done = 0;
    logic           done_q = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock; new oscillator levels appear 1 ns after the edge and are logged.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (per[i] == 0) osc_in[i] = 1'($urandom_range(0, 1));
            else osc_in[i] = (((cyc + ph[i]) % per[i]) < (per[i] / 2));
        end
        if (cyc < HMAX) hist[cyc] = osc_in;
    endtask

    // Rising edges at the pin in cycle k are seen two cycles later; a window whose done
    // falls in cycle d covers GATE cycles d-G .. d-1.
    function automatic int model_count(input int ch, input int d);
        int n = 0;
        for (int k = d - G - 2; k <= d - 3; k++) begin
            if (k >= 1 && k < HMAX && hist[k][ch] && !hist[k-1][ch]) n++;
        end
        return n;
    endfunction

    always @(negedge clk) begin
        if (done && done_q) dbl_done++;
        done_q = done;
    end

    task automatic start_run(input int ch, input bit hold, output int c0);
        tick();
        ch_sel = SW'(ch);
        start = 1'b1;
        c0 = cyc;
        tick();
        if (!hold) start = 1'b0;
        @(negedge clk);
        check_eq("start_busy", busy, 1);
        check_eq("start_osc_en", osc_en, 32'(1) << ch);
    endtask

    task automatic expect_done(input int d, input int ch, input string tag);
        int early = 0;
        int n;
        int er;
        while (cyc < d) begin
            tick();
            @(negedge clk);
            if (cyc < d && done) early++;
        end
        n  = model_count(ch, d);
        er = (n > MAXV) ? MAXV : n;
        check_eq({tag, "_early_done"}, early, 0);
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_result"}, result, er);
        check_eq({tag, "_ovf"}, ovf, (n > MAXV) ? 1 : 0);
        last_res = er;
        last_ovf = (n > MAXV) ? 1 : 0;
    endtask

    task automatic expect_idle(input string tag);
        tick();
        @(negedge clk);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_osc_en"}, osc_en, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    initial begin
        int c0;
        int d;
        int ch;
        int quiet;
        for (int i = 0; i < HMAX; i++) hist[i] = '0;
        for (int i = 0; i < NCH; i++) begin
            per[i] = 0;
            ph[i]  = 0;
        end

        tick();
        tick();
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_osc_en", osc_en, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_ovf", ovf, 0);
        tick();
        rst_n = 1'b1;
        ena = 1'b1;
        tick();

        // One-shot, channel 2, period 8.
        per[2] = 8; per[0] = 0; per[1] = 0;
        start_run(2, 1'b0, c0);
        expect_done(c0 + S + G + 1, 2, "p8");
        check_eq("p8_near_128", (result >= 127 && result <= 129) ? 1 : 0, 1);
        expect_idle("p8_after");

        // Saturation at period 4, then a clean run at period 16.
        per[0] = 4; ph[0] = 1;
        start_run(0, 1'b0, c0);
        expect_done(c0 + S + G + 1, 0, "p4_sat");
        check_eq("p4_sat_255", result, MAXV);
        expect_idle("p4_after");
        per[0] = 16;
        start_run(0, 1'b0, c0);
        expect_done(c0 + S + G + 1, 0, "p16");
        check_eq("p16_ovf_clear", ovf, 0);

        // Randomized one-shot runs.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NCH; i++) begin
                per[i] = $urandom_range(0, 20);
                if (per[i] == 1) per[i] = 2;
                ph[i] = $urandom_range(0, 19);
            end
            ch = $urandom_range(0, NCH - 1);
            start_run(ch, 1'b0, c0);
            expect_done(c0 + S + G + 1, ch, "rand");
            expect_idle("rand_after");
        end

        // Continuous mode, channel 1, period 10; ch_sel moves mid-run, cont drops in window 3.
        per[1] = 10; ph[1] = 3;
        cont = 1'b1;
        start_run(1, 1'b0, c0);
        d = c0 + S + G + 1;
        expect_done(d, 1, "cont1");
        check_eq("cont1_near_102", (result >= 101 && result <= 103) ? 1 : 0, 1);
        ch_sel = 2'd0;
        d = d + G + 1;
        expect_done(d, 1, "cont2");
        check_eq("cont2_osc_en", osc_en, 3'b010);
        tick();
        @(negedge clk);
        check_eq("cont3_busy", busy, 1);
        cont = 1'b0;
        d = d + G + 1;
        expect_done(d, 1, "cont3");
        expect_idle("cont_after");

        // Abort with ena low in GATE cycle 500.
        per[2] = $urandom_range(2, 12);
        start_run(2, 1'b0, c0);
        while (cyc < c0 + S + 500) tick();
        ena = 1'b0;
        tick();
        ena = 1'b1;
        @(negedge clk);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_osc_en", osc_en, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_result", result, last_res);
        check_eq("abort_ovf", ovf, last_ovf);
        quiet = 0;
        for (int i = 0; i < G; i++) begin
            tick();
            @(negedge clk);
            if (done || busy) quiet++;
        end
        check_eq("abort_stays_idle", quiet, 0);
        start_run(2, 1'b0, c0);
        expect_done(c0 + S + G + 1, 2, "post_abort");

        // Out-of-range channel is ignored.
        tick();
        ch_sel = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check_eq("badch_busy", busy, 0);
        check_eq("badch_osc_en", osc_en, 0);

        // start held high: one run, one IDLE cycle, then an immediate restart.
        per[0] = $urandom_range(2, 16);
        start_run(0, 1'b1, c0);
        d = c0 + S + G + 1;
        expect_done(d, 0, "held1");
        tick();
        @(negedge clk);
        check_eq("held_idle_gap", busy, 0);
        tick();
        start = 1'b0;
        @(negedge clk);
        check_eq("held_restart_busy", busy, 1);
        d = d + 1 + S + G + 1;
        expect_done(d, 0, "held2");
        expect_idle("held_after");

        // Asynchronous reset in the middle of SETTLE, away from a clock edge.
        start_run(1, 1'b0, c0);
        tick();
        tick();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_osc_en", osc_en, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_result", result, 0);
        check_eq("arst_ovf", ovf, 0);
        tick();
        #2 rst_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            @(negedge clk);
            if (done || busy || (osc_en != 0) || (result != 0)) quiet++;
        end
        check_eq("arst_stays_zero", quiet, 0);
        start_run(1, 1'b0, c0);
        expect_done(c0 + S + G + 1, 1, "post_arst");

        check_eq("no_double_done", dbl_done, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
